// File: rtl/swim_rx.sv
// swim_rx: STM8 SWIM receive decoder (pulse-width bit slicer, frame assembler).
// Define SWIM_RX_ACK_EN to answer each completed frame with an ack/nack on swim_oe.
module swim_rx #(
    parameter int BIT_THRESH   = 66,
    parameter int MIN_LOW      = 3,
    parameter int TIMEOUT      = 528,
    parameter int START_VAL    = 1,
    parameter int ACK_GAP      = 16,
    parameter int ACK_LOW_ONE  = 12,
    parameter int ACK_LOW_ZERO = 120
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       swim_in,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overrun,
    output logic       swim_oe
);

    localparam logic [15:0] THRESH_W = 16'(BIT_THRESH);
    localparam logic [15:0] MIN_W    = 16'(MIN_LOW);
    localparam logic [15:0] TOUT_W   = 16'(TIMEOUT);
    localparam logic        START_B  = 1'(START_VAL);

`ifdef SWIM_RX_ACK_EN
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOW,
        S_HIGH,
        S_ACK_WAIT,
        S_ACK_DRIVE
    } state_t;
    localparam state_t S_DONE = S_ACK_WAIT;
    localparam logic [15:0] GAP_W  = 16'(ACK_GAP);
    localparam logic [15:0] ONE_W  = 16'(ACK_LOW_ONE);
    localparam logic [15:0] ZERO_W = 16'(ACK_LOW_ZERO);
`else
    typedef enum logic [1:0] {
        S_IDLE,
        S_LOW,
        S_HIGH
    } state_t;
    localparam state_t S_DONE = S_IDLE;
`endif

    logic        sync1;
    logic        sync2;
    logic        line_d;
    logic        fall;
    logic        rise;
    state_t      state;
    logic        from_high;
    logic [3:0]  bit_cnt;
    logic [15:0] wcnt;
    logic [15:0] tcnt;
    logic [7:0]  shreg;
    logic [15:0] wcnt_nx;
    logic [15:0] tcnt_nx;
    logic        bit_val;
    logic        glitch;
    logic        par_ok;
    logic        can_load;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1  <= 1'b1;
            sync2  <= 1'b1;
            line_d <= 1'b1;
        end else begin
            sync1  <= swim_in;
            sync2  <= sync1;
            line_d <= sync2;
        end
    end

    assign fall     = line_d & ~sync2;
    assign rise     = ~line_d & sync2;
    assign wcnt_nx  = (&wcnt) ? wcnt : wcnt + 16'd1;
    assign tcnt_nx  = (&tcnt) ? tcnt : tcnt + 16'd1;
    assign bit_val  = wcnt < THRESH_W;
    assign glitch   = wcnt < MIN_W;
    assign par_ok   = (^shreg) == bit_val;
    assign can_load = ~rx_valid | rx_ready;

`ifdef SWIM_RX_ACK_EN
    logic        ack_good;
    logic [15:0] ack_len;

    assign ack_len = ack_good ? ONE_W : ZERO_W;
`else
    logic unused_ack;

    assign unused_ack = ^{ACK_GAP, ACK_LOW_ONE, ACK_LOW_ZERO};
    assign swim_oe    = 1'b0;
`endif

    // wcnt: width of the current low pulse; tcnt: time since the last
    // falling edge that produced a real bit (glitches leave it running).
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            from_high  <= 1'b0;
            bit_cnt    <= 4'd0;
            wcnt       <= 16'd0;
            tcnt       <= 16'd0;
            shreg      <= 8'd0;
            rx_data    <= 8'd0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
`ifdef SWIM_RX_ACK_EN
            ack_good   <= 1'b0;
            swim_oe    <= 1'b0;
`endif
        end else begin
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
            unique case (state)
                S_IDLE: begin
                    if (fall) begin
                        state     <= S_LOW;
                        from_high <= 1'b0;
                        bit_cnt   <= 4'd0;
                        wcnt      <= 16'd1;
                        tcnt      <= 16'd1;
                    end
                end
                S_LOW: begin
                    wcnt <= wcnt_nx;
                    tcnt <= tcnt_nx;
                    if (rise) begin
                        if (glitch) begin
                            state <= from_high ? S_HIGH : S_IDLE;
                        end else if (bit_cnt == 4'd0) begin
                            if (bit_val != START_B) begin
                                frame_err <= 1'b1;
                                state     <= S_IDLE;
                            end else begin
                                bit_cnt <= 4'd1;
                                tcnt    <= wcnt_nx;
                                state   <= S_HIGH;
                            end
                        end else if (bit_cnt == 4'd9) begin
                            bit_cnt <= 4'd0;
                            wcnt    <= 16'd0;
                            state   <= S_DONE;
                            if (!par_ok) begin
                                parity_err <= 1'b1;
                            end else if (can_load) begin
                                rx_data  <= shreg;
                                rx_valid <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
`ifdef SWIM_RX_ACK_EN
                            ack_good <= par_ok & can_load;
`endif
                        end else begin
                            shreg   <= {shreg[6:0], bit_val};
                            bit_cnt <= bit_cnt + 4'd1;
                            tcnt    <= wcnt_nx;
                            state   <= S_HIGH;
                        end
                    end
                end
                S_HIGH: begin
                    tcnt <= tcnt_nx;
                    if (fall) begin
                        state     <= S_LOW;
                        from_high <= 1'b1;
                        wcnt      <= 16'd1;
                    end else if (tcnt >= TOUT_W && bit_cnt != 4'd0) begin
                        frame_err <= 1'b1;
                        bit_cnt   <= 4'd0;
                        state     <= S_IDLE;
                    end
                end
`ifdef SWIM_RX_ACK_EN
                S_ACK_WAIT: begin
                    if (fall) begin
                        state     <= S_LOW;
                        from_high <= 1'b0;
                        bit_cnt   <= 4'd0;
                        wcnt      <= 16'd1;
                        tcnt      <= 16'd1;
                    end else if (sync2) begin
                        wcnt <= wcnt_nx;
                        if (wcnt_nx >= GAP_W) begin
                            state   <= S_ACK_DRIVE;
                            swim_oe <= 1'b1;
                            wcnt    <= 16'd1;
                        end
                    end
                end
                // Our own low pulse echoes back through the synchroniser;
                // edges are ignored here and the trailing rise is harmless in IDLE.
                S_ACK_DRIVE: begin
                    if (wcnt >= ack_len) begin
                        swim_oe <= 1'b0;
                        state   <= S_IDLE;
                    end else begin
                        wcnt <= wcnt_nx;
                    end
                end
`endif
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_swim_rx.sv
// tb_swim_rx: vector table, hand-built corner sequences and random frames
// checked against a width-rule frame model for swim_rx.
module tb_swim_rx;

    logic       clk      = 1'b0;
    logic       reset    = 1'b1;
    logic       swim_in  = 1'b1;
    logic       rx_ready = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       parity_err;
    logic       frame_err;
    logic       overrun;
    logic       swim_oe;

    always #5 clk = ~clk;

    swim_rx dut (
        .clk        (clk),
        .reset      (reset),
        .swim_in    (swim_in),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .swim_oe    (swim_oe)
    );

    int n_chk    = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int n_perr   = 0;
    int n_ferr   = 0;
    int n_ovr    = 0;
    int n_vcyc   = 0;
    int n_oe     = 0;
    int ferr_cyc = 0;
    logic [7:0] got_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        #1;
        if (!reset) begin
            if (rx_valid && rx_ready) got_q.push_back(rx_data);
            if (rx_valid) n_vcyc++;
            if (parity_err) n_perr++;
            if (overrun) n_ovr++;
            if (swim_oe) n_oe++;
            if (frame_err) begin
                n_ferr++;
                ferr_cyc = cyc;
            end
        end
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: run did not finish, cycle %0d, limit 150000", cyc);
        $fatal(1);
    end

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", name, act, exp);
    endtask

    task automatic check_rng(input string name, input int act, input int lo, input int hi);
        n_chk++;
        if (act >= lo && act <= hi) n_pass++;
        else $display("FAIL %s: got %0d, want %0d..%0d", name, act, lo, hi);
    endtask

    task automatic hold(input logic lv, input int n);
        swim_in = lv;
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input int lo, input int hi, input logic gl);
        hold(1'b0, lo);
        if (gl) begin
            hold(1'b1, hi / 2 - 1);
            hold(1'b0, 2);
            hold(1'b1, hi - hi / 2 - 1);
        end else begin
            hold(1'b1, hi);
        end
    endtask

    task automatic send_bit(input logic b, input int lo1, input int lo0, input logic gl);
        int lo;
        lo = b ? lo1 : lo0;
        pulse(lo, 132 - lo, gl);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic flip, input logic gl,
                              input int lo1, input int lo0);
        send_bit(1'b1, lo1, lo0, gl);
        for (int i = 7; i >= 0; i--) send_bit(d[i], lo1, lo0, gl);
        send_bit((^d) ^ flip, lo1, lo0, gl);
        hold(1'b1, 200);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       flip;
        logic       bad_start;
        int         exp_bytes;
        logic [7:0] exp_data;
        int         exp_perr;
        int         exp_ferr;
        int         exp_oe;
    } vec_t;

    vec_t vt[7];

    int p0, f0, o0, v0, e0, t_fall;
    int lows[10];
    int highs[10];
    logic [7:0] exp_q[$];
    int exp_perr;

    initial begin
        vt[0] = '{8'hA5, 1'b0, 1'b0, 1, 8'hA5, 0, 0, 12};
        vt[1] = '{8'hA5, 1'b1, 1'b0, 0, 8'h00, 1, 0, 120};
        vt[2] = '{8'h00, 1'b0, 1'b1, 0, 8'h00, 0, 1, 0};
        vt[3] = '{8'h01, 1'b0, 1'b0, 1, 8'h01, 0, 0, 12};
        vt[4] = '{8'hFF, 1'b0, 1'b0, 1, 8'hFF, 0, 0, 12};
        vt[5] = '{8'h00, 1'b0, 1'b0, 1, 8'h00, 0, 0, 12};
        vt[6] = '{8'h55, 1'b1, 1'b0, 0, 8'h00, 1, 0, 120};

        repeat (3) @(negedge clk);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_data", rx_data, 0);
        check("rst_parity_err", parity_err, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_overrun", overrun, 0);
        check("rst_swim_oe", swim_oe, 0);
        reset = 1'b0;
        hold(1'b1, 20);

        for (int i = 0; i < 7; i++) begin
            got_q.delete();
            p0 = n_perr; f0 = n_ferr; o0 = n_ovr; v0 = n_vcyc; e0 = n_oe;
            if (vt[i].bad_start) begin
                pulse(120, 12, 1'b0);
                hold(1'b1, 200);
            end else begin
                send_frame(vt[i].data, vt[i].flip, 1'b0, 12, 120);
            end
            check($sformatf("v%0d_bytes", i), got_q.size(), vt[i].exp_bytes);
            check($sformatf("v%0d_data", i),
                  got_q.size() > 0 ? int'(got_q[0]) : -1,
                  vt[i].exp_bytes > 0 ? int'(vt[i].exp_data) : -1);
            check($sformatf("v%0d_valid_cycles", i), n_vcyc - v0, vt[i].exp_bytes);
            check($sformatf("v%0d_parity_err", i), n_perr - p0, vt[i].exp_perr);
            check($sformatf("v%0d_frame_err", i), n_ferr - f0, vt[i].exp_ferr);
            check($sformatf("v%0d_overrun", i), n_ovr - o0, 0);
`ifdef SWIM_RX_ACK_EN
            check($sformatf("v%0d_ack_len", i), n_oe - e0, vt[i].exp_oe);
`endif
        end

        // overrun: two frames with nobody reading
        got_q.delete();
        o0 = n_ovr;
        rx_ready = 1'b0;
        send_frame(8'h3C, 1'b0, 1'b0, 12, 120);
        check("ovr_first_valid", rx_valid, 1);
        check("ovr_first_data", rx_data, 8'h3C);
        send_frame(8'hC3, 1'b0, 1'b0, 12, 120);
        check("ovr_count", n_ovr - o0, 1);
        check("ovr_kept_data", rx_data, 8'h3C);
        check("ovr_still_valid", rx_valid, 1);
        rx_ready = 1'b1;
        @(negedge clk);
        check("ovr_valid_drop", rx_valid, 0);
        hold(1'b1, 5);
        check("ovr_bytes", got_q.size(), 1);
        check("ovr_byte", got_q.size() > 0 ? int'(got_q[0]) : -1, 8'h3C);

        // timeout: start + 3 data bits then idle
        f0 = n_ferr;
        send_bit(1'b1, 12, 120, 1'b0);
        send_bit(1'b1, 12, 120, 1'b0);
        send_bit(1'b0, 12, 120, 1'b0);
        t_fall = cyc;
        pulse(12, 600, 1'b0);
        check("tmo_frame_err", n_ferr - f0, 1);
        check_rng("tmo_latency", ferr_cyc - t_fall, 527, 535);
        got_q.delete();
        send_frame(8'h81, 1'b0, 1'b0, 12, 120);
        check("tmo_recover", got_q.size() > 0 ? int'(got_q[0]) : -1, 8'h81);

        // glitches inside every high phase
        got_q.delete();
        p0 = n_perr; f0 = n_ferr;
        send_frame(8'h55, 1'b0, 1'b1, 12, 120);
        check("glitch_byte", got_q.size() > 0 ? int'(got_q[0]) : -1, 8'h55);
        check("glitch_errs", (n_perr - p0) + (n_ferr - f0), 0);

        // width boundaries: 3 and 65 are '1', 66 is '0'
        got_q.delete();
        send_frame(8'h96, 1'b0, 1'b0, 3, 66);
        send_frame(8'h69, 1'b0, 1'b0, 65, 66);
        check("bnd_bytes", got_q.size(), 2);
        check("bnd_min_low", got_q.size() > 0 ? int'(got_q[0]) : -1, 8'h96);
        check("bnd_thresh", got_q.size() > 1 ? int'(got_q[1]) : -1, 8'h69);

        // line held low for a long time from idle
        got_q.delete();
        f0 = n_ferr;
        pulse(3000, 200, 1'b0);
        check("held_low_ferr", n_ferr - f0, 1);
        check("held_low_bytes", got_q.size(), 0);

        // reset in the middle of a frame with a byte pending
        rx_ready = 1'b0;
        send_frame(8'h77, 1'b0, 1'b0, 12, 120);
        check("rstmid_pending", rx_valid, 1);
        send_bit(1'b1, 12, 120, 1'b0);
        send_bit(1'b0, 12, 120, 1'b0);
        send_bit(1'b1, 12, 120, 1'b0);
        pulse(12, 40, 1'b0);
        p0 = n_perr; f0 = n_ferr; o0 = n_ovr;
        reset = 1'b1;
        hold(1'b1, 3);
        check("rstmid_valid", rx_valid, 0);
        check("rstmid_data", rx_data, 0);
        check("rstmid_oe", swim_oe, 0);
        check("rstmid_pulses", {29'd0, parity_err, frame_err, overrun}, 0);
        reset = 1'b0;
        rx_ready = 1'b1;
        got_q.delete();
        hold(1'b1, 700);
        check("rstmid_quiet", (n_perr - p0) + (n_ferr - f0) + (n_ovr - o0), 0);
        check("rstmid_no_byte", got_q.size(), 0);
        send_frame(8'h5A, 1'b0, 1'b0, 12, 120);
        check("rstmid_recover", got_q.size() > 0 ? int'(got_q[0]) : -1, 8'h5A);

        // random widths; the model slices each low width by the threshold rule
        got_q.delete();
        exp_q.delete();
        exp_perr = 0;
        p0 = n_perr; f0 = n_ferr; o0 = n_ovr;
        for (int f = 0; f < 12; f++) begin
            logic [7:0] d;
            logic       pb;
            lows[0]  = $urandom_range(4, 65);
            highs[0] = $urandom_range(10, 150);
            for (int k = 1; k < 10; k++) begin
                lows[k]  = $urandom_range(4, 130);
                highs[k] = $urandom_range(10, 150);
            end
            for (int k = 0; k < 10; k++) pulse(lows[k], highs[k], 1'b0);
            hold(1'b1, 200);
            d = 8'd0;
            for (int k = 1; k <= 8; k++) d = {d[6:0], lows[k] < 66};
            pb = lows[9] < 66;
            if ((^d) == pb) exp_q.push_back(d);
            else exp_perr++;
        end
        check("rnd_count", got_q.size(), exp_q.size());
        for (int k = 0; k < exp_q.size(); k++) begin
            check($sformatf("rnd_byte%0d", k),
                  k < got_q.size() ? int'(got_q[k]) : -1, exp_q[k]);
        end
        check("rnd_parity_err", n_perr - p0, exp_perr);
        check("rnd_frame_err", n_ferr - f0, 0);
        check("rnd_overrun", n_ovr - o0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
